// File: rtl/systolic_sequencer.sv
// systolic_sequencer: two-pass control FSM for the 3x3 systolic convolution core.
// Pass 0 feeds FEED0_LEN entries, drains, shifts out and captures the three
// diagonal results. The array is then cleared, and pass 1 feeds FEED1_LEN
// entries, drains, shifts out and captures the summed fourth result.
// All outputs are Moore-decoded from the registered state and phase counter.
// Optional feature: define SYSTOLIC_SEQ_BACK2BACK_EN to let a start seen in
// DONE launch the next run directly, with no IDLE bubble.
module systolic_sequencer #(
  parameter int unsigned FEED0_LEN = 9,
  parameter int unsigned FEED1_LEN = 3,
  parameter int unsigned DRAIN_LEN = 6,
  parameter int unsigned SHIFT_LEN = 3
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sel,
  output logic       feed_valid,
  output logic       mode,
  output logic       pe_rst,
  output logic       cap0,
  output logic       cap1
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FEED0  = 4'd1,
    S_DRAIN0 = 4'd2,
    S_SHIFT0 = 4'd3,
    S_CAP0   = 4'd4,
    S_CLR    = 4'd5,
    S_FEED1  = 4'd6,
    S_DRAIN1 = 4'd7,
    S_SHIFT1 = 4'd8,
    S_CAP1   = 4'd9,
    S_DONE   = 4'd10,
    S_ABORT  = 4'd11
  } state_t;

  // Compare the counter against LEN-1 so that it never has to wrap.
  localparam logic [7:0] F0_LAST = 8'(FEED0_LEN - 1);
  localparam logic [7:0] F1_LAST = 8'(FEED1_LEN - 1);
  localparam logic [7:0] DR_LAST = 8'(DRAIN_LEN - 1);
  localparam logic [7:0] SH_LAST = 8'(SHIFT_LEN - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  state_t     w_state_next;
  logic [7:0] w_cnt_next;
  logic       w_timed;

  // State and phase counter registers; reset returns to IDLE at once.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, counter and Moore output decode.
  always_comb begin
    w_state_next = r_state;
    w_timed      = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    pass         = 1'b0;
    sel          = 4'd0;
    feed_valid   = 1'b0;
    mode         = 1'b0;
    pe_rst       = 1'b0;
    cap0         = 1'b0;
    cap1         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_next = S_FEED0;
      end
      S_FEED0: begin
        w_timed    = 1'b1;
        feed_valid = 1'b1;
        sel        = r_cnt[3:0];
        if (r_cnt == F0_LAST) w_state_next = S_DRAIN0;
      end
      S_DRAIN0: begin
        w_timed = 1'b1;
        if (r_cnt == DR_LAST) w_state_next = S_SHIFT0;
      end
      S_SHIFT0: begin
        w_timed = 1'b1;
        mode    = 1'b1;
        if (r_cnt == SH_LAST) w_state_next = S_CAP0;
      end
      S_CAP0: begin
        cap0         = 1'b1;
        w_state_next = S_CLR;
      end
      S_CLR: begin
        pass         = 1'b1;
        pe_rst       = 1'b1;
        w_state_next = S_FEED1;
      end
      S_FEED1: begin
        w_timed    = 1'b1;
        pass       = 1'b1;
        feed_valid = 1'b1;
        sel        = r_cnt[3:0];
        if (r_cnt == F1_LAST) w_state_next = S_DRAIN1;
      end
      S_DRAIN1: begin
        w_timed = 1'b1;
        pass    = 1'b1;
        if (r_cnt == DR_LAST) w_state_next = S_SHIFT1;
      end
      S_SHIFT1: begin
        w_timed = 1'b1;
        pass    = 1'b1;
        mode    = 1'b1;
        if (r_cnt == SH_LAST) w_state_next = S_CAP1;
      end
      S_CAP1: begin
        pass         = 1'b1;
        cap1         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        pass = 1'b1;
        done = 1'b1;
`ifdef SYSTOLIC_SEQ_BACK2BACK_EN
        if (start && !abort) w_state_next = S_FEED0;
        else                 w_state_next = S_IDLE;
`else
        w_state_next = S_IDLE;
`endif
      end
      S_ABORT: begin
        pe_rst       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides every transition of a run in progress.
    if (abort && (r_state != S_IDLE) && (r_state != S_ABORT))
      w_state_next = S_ABORT;

    // Counter restarts on every state change and only runs in timed states.
    if (w_state_next != r_state) w_cnt_next = 8'd0;
    else if (w_timed)            w_cnt_next = r_cnt + 8'd1;
    else                         w_cnt_next = 8'd0;
  end

endmodule
